// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch / program-counter stage of the KGP-RISC core. Holds the
//   PC, reads one instruction word per fetch over a req/ack handshake, presents
//   it to decode/execute, then advances the PC using the next-PC select that
//   control_unit returns when execution completes. Fetch time-outs and
//   misaligned register-jump targets park the unit in HALT until reset.
//
// Parameters
//   RESET_PC       PC loaded on reset (word-aligned)
//   FETCH_TIMEOUT  request cycles without ack before halting (1..255)
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   o_imem_req/addr      instruction-memory read request and byte address
//   i_imem_ack/rdata     memory acknowledge and returned instruction word
//   o_instruction        latched instruction word
//   o_instr_valid        instruction awaiting execution
//   o_pc, o_pc_plus4     current PC and PC+4 (CALL link value)
//   i_pc_control         next-PC select: 0000 seq, 0001 reg target, 0010 branch
//   i_reg_rs_data        register target for BR / RET
//   i_exec_done          datapath finished; i_pc_control valid this cycle
//   o_halted, o_err_code HALT flag and cause (01 misaligned, 10 time-out)
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int unsigned FETCH_TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_instruction,
   output logic        o_instr_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4,
   input  logic [3:0]  i_pc_control,
   input  logic [31:0] i_reg_rs_data,
   input  logic        i_exec_done,
   output logic        o_halted,
   output logic [1:0]  o_err_code
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [3:0] PCC_SEQ = 4'b0000;
   localparam logic [3:0] PCC_REG = 4'b0001;
   localparam logic [3:0] PCC_BR  = 4'b0010;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   localparam logic [7:0] TIMEOUT_C = 8'(FETCH_TIMEOUT);

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instruction;
   logic        r_imem_req;
   logic        r_instr_valid;
   logic        r_halted;
   logic [1:0]  r_err_code;
   logic [7:0]  r_cnt;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_off;
   logic [31:0] w_br_target;
   logic [7:0]  w_cnt_inc;

   // Branch/CALL offset: 26-bit word offset, sign-extended, scaled to bytes,
   // relative to the sequential PC.
   assign w_pc_plus4  = r_pc + 32'd4;
   assign w_br_off    = {{4{r_instruction[25]}}, r_instruction[25:0], 2'b00};
   assign w_br_target = w_pc_plus4 + w_br_off;
   assign w_cnt_inc   = r_cnt + 8'd1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_instruction <= 32'd0;
         r_imem_req    <= 1'b0;
         r_instr_valid <= 1'b0;
         r_halted      <= 1'b0;
         r_err_code    <= ERR_NONE;
         r_cnt         <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state    <= S_FETCH;
               r_imem_req <= 1'b1;
            end

            S_FETCH: begin
               if (i_imem_ack) begin
                  r_instruction <= i_imem_rdata;
                  r_cnt         <= 8'd0;
                  r_imem_req    <= 1'b0;
                  r_instr_valid <= 1'b1;
                  r_state       <= S_ISSUE;
               end else if (w_cnt_inc == TIMEOUT_C) begin
                  r_cnt      <= w_cnt_inc;
                  r_imem_req <= 1'b0;
                  r_halted   <= 1'b1;
                  r_err_code <= ERR_TIMEOUT;
                  r_state    <= S_HALT;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            S_ISSUE: begin
               if (i_exec_done) begin
                  r_instr_valid <= 1'b0;
                  // A misaligned register target halts with the PC left on
                  // the faulting instruction so software can inspect it.
                  if (i_pc_control == PCC_REG && i_reg_rs_data[1:0] != 2'b00) begin
                     r_halted   <= 1'b1;
                     r_err_code <= ERR_MISALIGN;
                     r_state    <= S_HALT;
                  end else begin
                     r_imem_req <= 1'b1;
                     r_state    <= S_FETCH;
                     case (i_pc_control)
                        PCC_REG: r_pc <= i_reg_rs_data;
                        PCC_BR:  r_pc <= w_br_target;
                        default: r_pc <= w_pc_plus4; // 0000 and undefined codes
                     endcase
                  end
               end
            end

            S_HALT: begin
               // Terminal until reset; everything else stays frozen.
               r_imem_req    <= 1'b0;
               r_instr_valid <= 1'b0;
               r_halted      <= 1'b1;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_imem_req    = r_imem_req;
   assign o_imem_addr   = r_pc;
   assign o_instruction = r_instruction;
   assign o_instr_valid = r_instr_valid;
   assign o_pc          = r_pc;
   assign o_pc_plus4    = w_pc_plus4;
   assign o_halted      = r_halted;
   assign o_err_code    = r_err_code;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [3:0]  pc_control;
   logic [31:0] reg_rs_data;
   logic        exec_done;
   logic        halted;
   logic [1:0]  err_code;

   int total = 0;
   int bad   = 0;

   fetch_unit #(
      .RESET_PC      (32'h0000_0100),
      .FETCH_TIMEOUT (4)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_ack    (imem_ack),
      .i_imem_rdata  (imem_rdata),
      .o_instruction (instruction),
      .o_instr_valid (instr_valid),
      .o_pc          (pc),
      .o_pc_plus4    (pc_plus4),
      .i_pc_control  (pc_control),
      .i_reg_rs_data (reg_rs_data),
      .i_exec_done   (exec_done),
      .o_halted      (halted),
      .o_err_code    (err_code)
   );

   always #5 clk = ~clk;

   // Advance one edge; sample and drive 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      imem_ack    = 1'b0;
      imem_rdata  = 32'd0;
      exec_done   = 1'b0;
      pc_control  = 4'd0;
      reg_rs_data = 32'd0;
   endtask

   // Zero-wait fetch of rdata, then execute with the given next-PC select.
   task automatic run_instr(input logic [31:0] rdata, input logic [3:0] pcc,
                            input logic [31:0] rs);
      imem_ack = 1'b1; imem_rdata = rdata;
      tick();
      imem_ack = 1'b0;
      exec_done = 1'b1; pc_control = pcc; reg_rs_data = rs;
      tick();
      idle_inputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      do_reset();
      total++;
      if (pc !== 32'h100) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h100); end
      total++;
      if ({imem_req, instr_valid, halted, err_code} !== 5'b0) begin
         bad++; $display("FAIL reset_outs got=%b exp=%b", {imem_req, instr_valid, halted, err_code}, 5'b0);
      end
      total++;
      if (instruction !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instruction); end
      total++;
      if (pc_plus4 !== 32'h104) begin bad++; $display("FAIL reset_pcp4 got=%h exp=%h", pc_plus4, 32'h104); end
      tick(); // IDLE -> FETCH
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         bad++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=00000100", imem_req, imem_addr);
      end
   endtask

   task automatic test_seq_wait();
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL wait_hold%0d got req=%b addr=%h vld=%b", i, imem_req, imem_addr, instr_valid);
         end
      end
      imem_ack = 1'b1; imem_rdata = 32'h0022_1820;
      tick();
      imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      total++;
      if (instruction !== 32'h0022_1820 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
         bad++; $display("FAIL seq_latch got instr=%h vld=%b req=%b exp 00221820/1/0", instruction, instr_valid, imem_req);
      end
      // ack during ISSUE must be ignored
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      total++;
      if (instruction !== 32'h0022_1820 || instr_valid !== 1'b1) begin
         bad++; $display("FAIL issue_ack_ignored got instr=%h vld=%b", instruction, instr_valid);
      end
      exec_done = 1'b1; pc_control = 4'b0000;
      tick();
      idle_inputs();
      total++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h104) begin
         bad++; $display("FAIL seq_next got vld=%b req=%b addr=%h exp 0/1/00000104", instr_valid, imem_req, imem_addr);
      end
      // exec_done during FETCH must be ignored
      exec_done = 1'b1; pc_control = 4'b0001; reg_rs_data = 32'h0000_0800;
      tick();
      idle_inputs();
      total++;
      if (pc !== 32'h104 || imem_req !== 1'b1) begin
         bad++; $display("FAIL fetch_exec_ignored got pc=%h req=%b exp 00000104/1", pc, imem_req);
      end
   endtask

   task automatic test_reg_jump();
      run_instr(32'h0, 4'b0001, 32'h0000_0400);
      total++;
      if (pc !== 32'h400 || imem_req !== 1'b1) begin
         bad++; $display("FAIL reg_jump got pc=%h req=%b exp 00000400/1", pc, imem_req);
      end
   endtask

   task automatic test_branch();
      run_instr(32'h0, 4'b0001, 32'h0000_0200);
      run_instr(32'h03FF_FFFE, 4'b0010, 32'h0);
      total++;
      if (pc !== 32'h1FC) begin bad++; $display("FAIL branch_back got=%h exp=000001fc", pc); end
      run_instr(32'h0, 4'b0001, 32'h0000_0200);
      run_instr(32'h0000_0003, 4'b0010, 32'h0);
      total++;
      if (pc !== 32'h210) begin bad++; $display("FAIL branch_fwd got=%h exp=00000210", pc); end
      // undefined select behaves as sequential
      run_instr(32'h0000_0003, 4'b1010, 32'h0000_0800);
      total++;
      if (pc !== 32'h214 || pc_plus4 !== 32'h218) begin
         bad++; $display("FAIL undef_pcc got pc=%h p4=%h exp 00000214/00000218", pc, pc_plus4);
      end
   endtask

   task automatic test_wrap();
      run_instr(32'h0, 4'b0001, 32'hFFFF_FFFC);
      total++;
      if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
         bad++; $display("FAIL wrap_p4 got pc=%h p4=%h exp fffffffc/00000000", pc, pc_plus4);
      end
      run_instr(32'h0, 4'b0000, 32'h0);
      total++;
      if (pc !== 32'h0 || imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_seq got=%h exp=00000000", pc); end
   endtask

   task automatic test_misalign();
      run_instr(32'h0, 4'b0001, 32'h0000_0400);
      run_instr(32'h1234_5678, 4'b0001, 32'h0000_0402);
      total++;
      if (halted !== 1'b1 || err_code !== 2'b01) begin
         bad++; $display("FAIL misalign_halt got halted=%b err=%b exp 1/01", halted, err_code);
      end
      total++;
      if (pc !== 32'h400 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         bad++; $display("FAIL misalign_state got pc=%h req=%b vld=%b exp 00000400/0/0", pc, imem_req, instr_valid);
      end
      imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555; exec_done = 1'b1;
      tick(); tick();
      idle_inputs();
      total++;
      if (halted !== 1'b1 || pc !== 32'h400 || instruction !== 32'h1234_5678 || imem_req !== 1'b0) begin
         bad++; $display("FAIL halt_frozen got h=%b pc=%h instr=%h req=%b", halted, pc, instruction, imem_req);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      tick(); // IDLE -> FETCH
      for (int i = 1; i <= 3; i++) begin
         tick();
         total++;
         if (halted !== 1'b0 || imem_req !== 1'b1) begin
            bad++; $display("FAIL timeout_early%0d got halted=%b req=%b exp 0/1", i, halted, imem_req);
         end
      end
      tick();
      total++;
      if (halted !== 1'b1 || err_code !== 2'b10 || imem_req !== 1'b0) begin
         bad++; $display("FAIL timeout_halt got halted=%b err=%b req=%b exp 1/10/0", halted, err_code, imem_req);
      end
      tick();
      total++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h100) begin
         bad++; $display("FAIL timeout_hold got halted=%b req=%b pc=%h", halted, imem_req, pc);
      end
   endtask

   task automatic test_reset_mid_fetch();
      do_reset();
      total++;
      if (halted !== 1'b0 || err_code !== 2'b00) begin
         bad++; $display("FAIL halt_cleared got halted=%b err=%b exp 0/00", halted, err_code);
      end
      tick(); // FETCH at 0x100
      run_instr(32'h0, 4'b0000, 32'h0); // now FETCH at 0x104
      tick(); // one wait cycle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (imem_req !== 1'b0 || pc !== 32'h100) begin
         bad++; $display("FAIL mid_rst got req=%b pc=%h exp 0/00000100", imem_req, pc);
      end
      imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
      tick();
      idle_inputs();
      total++;
      if (instr_valid !== 1'b0 || instruction !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         bad++; $display("FAIL late_ack got vld=%b instr=%h req=%b addr=%h exp 0/0/1/00000100",
                         instr_valid, instruction, imem_req, imem_addr);
      end
      tick();
      total++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
         bad++; $display("FAIL post_rst_fetch got vld=%b req=%b exp 0/1", instr_valid, imem_req);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_seq_wait();
      test_reg_jump();
      test_branch();
      test_wrap();
      test_misalign();
      test_timeout();
      test_reset_mid_fetch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
